ariane_operand_fetch: RTL and testbench
=======================================

ARIANE_OPERAND_FETCH -- requirements
Module: ariane_operand_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/register width.
REQ-002 SHALL have parameter NR_READ_PORTS, default 2, source operands per instruction; equals regfile read ports.
REQ-003 SHALL have parameter NR_WRITE_PORTS, default 2, writeback ports snooped; equals regfile write ports.
REQ-004 SHALL have parameter ZERO_REG_ZERO, default 1, x0 reads as zero and is never busy.
REQ-005 SHALL have one clock and a synchronous active-high reset: clk_i  in  1  clock, rising edge; rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have issue_valid_i  in  1  / issue_ready_o  out  1  issue handshake.
REQ-007 SHALL have issue_rs_i  in  [NR_READ_PORTS][5]  source addresses; issue_rd_i  in  5  destination; issue_rd_we_i  in  1  writes rd.
REQ-008 SHALL have raddr_o  out  [NR_READ_PORTS][5]  regfile read addresses; rdata_i  in  [NR_READ_PORTS][DATA_WIDTH]  combinational regfile read data.
REQ-009 SHALL have wb_we_i  in  [NR_WRITE_PORTS]; wb_addr_i  in  [NR_WRITE_PORTS][5]; wb_data_i  in  [NR_WRITE_PORTS][DATA_WIDTH]  (same signals driving the regfile write ports).
REQ-010 SHALL have op_valid_o  out  1 / op_ready_i  in  1  dispatch handshake; op_data_o  out  [NR_READ_PORTS][DATA_WIDTH]; op_rd_o  out  5; op_rd_we_o  out  1.

Function
REQ-011 SHALL implement FSM IDLE, WAIT_OPS, HOLD.
REQ-012 issue_ready_o SHALL be 1 in IDLE, and in HOLD when op_ready_i=1; 0 otherwise and 0 while rst_i=1.
REQ-013 On issue handshake SHALL latch rs/rd/rd_we and enter WAIT_OPS next cycle; per-operand captured flags cleared.
REQ-014 In WAIT_OPS raddr_o SHALL equal latched rs; in other states raddr_o SHALL be 0.
REQ-015 Operand k available when: rs=0 and ZERO_REG_ZERO (value 0), or any wb_we_i[j] with wb_addr_i[j]=rs (value wb_data_i[j], forward), or busy[rs]=0 (value rdata_i[k]).
REQ-016 Forwarding SHALL take priority over rdata_i; on multiple matching write ports the highest index j wins.
REQ-017 Each operand SHALL be captured in the first WAIT_OPS cycle it is available and held thereafter.
REQ-018 WAIT_OPS -> HOLD when all operands captured (or captured this cycle) and not (rd_we and rd!=0 and busy[rd] and no wb clearing rd this cycle) (WAW stall).
REQ-019 op_valid_o SHALL be 1 exactly in HOLD; op_data_o/op_rd_o/op_rd_we_o stable while op_valid_o=1 and op_ready_i=0.
REQ-020 HOLD -> IDLE on op_ready_i=1 without new issue; HOLD -> WAIT_OPS on simultaneous dispatch and issue handshake.
REQ-021 Minimum latency: issue accept at edge N -> op_valid_o=1 in cycle N+2; throughput one instruction per 2 cycles.
REQ-022 Scoreboard busy[31:0]: set busy[rd] at dispatch handshake if rd_we and rd!=0; clear busy[a] for each wb_we_i with wb_addr_i=a.
REQ-023 Simultaneous set and clear of same register SHALL leave it set.
REQ-024 busy[0] SHALL remain 0 when ZERO_REG_ZERO=1.

Reset
REQ-025 rst_i SHALL force state IDLE, busy all 0, captured flags 0, op_valid_o 0, op_data_o 0, op_rd_o 0, op_rd_we_o 0.
REQ-026 Reset mid-operation SHALL discard the in-flight instruction with no busy bit set.

Structure
REQ-027 Package ariane_opfetch_pkg SHALL hold the state enum, REG_ADDR_WIDTH=5, NUM_REGS=32.
REQ-028 Scoreboard SHALL be sub-module ariane_scoreboard_bits (set/clear vector, set-wins).

Verification
REQ-029 After reset, x1=0x11, x2=0x22, issue rs=(1,2) rd=3 at edge N -> op_valid_o cycle N+2, op_data_o=(0x11,0x22), op_rd_o=3.
REQ-030 Dispatch rd=5; issue rs0=5 -> op_valid_o stays 0 until wb_we_i[0]=1 addr 5 data 0xDEAD; next cycle op_valid_o=1, op_data_o[0]=0xDEAD, busy[5]=0.
REQ-031 Ports 0 and 1 write addr 7 data 0xA/0xB same cycle while rs0=7 pending -> op_data_o[0]=0xB.
REQ-032 rs0=0, rdata_i[0]=0xFFFFFFFF -> op_data_o[0]=0; rd=0 dispatch leaves busy all 0.
REQ-033 op_ready_i low 3 cycles in HOLD -> outputs stable, busy[rd] set only on the handshake cycle.
REQ-034 rst_i pulsed in WAIT_OPS -> next cycle IDLE, op_valid_o=0, busy all 0.

Source files
------------

// File: rtl/ariane_opfetch_pkg.sv
// Shared types and constants for the operand fetch stage and its scoreboard.
package ariane_opfetch_pkg;

   localparam int REG_ADDR_WIDTH = 5;
   localparam int NUM_REGS       = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_OPS,
      HOLD
   } opfetch_state_e;

endpackage

// File: rtl/ariane_scoreboard_bits.sv
// One busy bit per architectural register; a set and a clear landing on the
// same register in the same cycle leaves the bit set.
module ariane_scoreboard_bits
   import ariane_opfetch_pkg::*;
#(
   parameter bit ZERO_REG_ZERO = 1'b1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NUM_REGS-1:0] set_i,
   input  logic [NUM_REGS-1:0] clr_i,
   output logic [NUM_REGS-1:0] busy_o
);

   logic [NUM_REGS-1:0] busy_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q <= '0;
      end else begin
         busy_q <= (busy_q & ~clr_i) | set_i;
         if (ZERO_REG_ZERO) busy_q[0] <= 1'b0;
      end
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/ariane_operand_fetch.sv
// Operand fetch: collects source operands from the regfile or writeback
// forwarding, stalls on busy sources and WAW hazards, then holds for dispatch.
module ariane_operand_fetch
   import ariane_opfetch_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int NR_READ_PORTS  = 2,
   parameter int NR_WRITE_PORTS = 2,
   parameter bit ZERO_REG_ZERO  = 1'b1
) (
   input  logic                                            clk_i,
   input  logic                                            rst_i,
   input  logic                                            issue_valid_i,
   output logic                                            issue_ready_o,
   input  logic [NR_READ_PORTS-1:0][REG_ADDR_WIDTH-1:0]    issue_rs_i,
   input  logic [REG_ADDR_WIDTH-1:0]                       issue_rd_i,
   input  logic                                            issue_rd_we_i,
   output logic [NR_READ_PORTS-1:0][REG_ADDR_WIDTH-1:0]    raddr_o,
   input  logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]        rdata_i,
   input  logic [NR_WRITE_PORTS-1:0]                       wb_we_i,
   input  logic [NR_WRITE_PORTS-1:0][REG_ADDR_WIDTH-1:0]   wb_addr_i,
   input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]       wb_data_i,
   output logic                                            op_valid_o,
   input  logic                                            op_ready_i,
   output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]        op_data_o,
   output logic [REG_ADDR_WIDTH-1:0]                       op_rd_o,
   output logic                                            op_rd_we_o
);

   opfetch_state_e                                  state_q;
   logic [NR_READ_PORTS-1:0][REG_ADDR_WIDTH-1:0]    rs_q;
   logic [REG_ADDR_WIDTH-1:0]                       rd_q;
   logic                                            rd_we_q;
   logic [NR_READ_PORTS-1:0]                        captured_q;
   logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]        op_data_q;

   logic [NR_READ_PORTS-1:0]                        avail;
   logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]        op_val;
   logic [NUM_REGS-1:0]                             busy;
   logic [NUM_REGS-1:0]                             set_vec;
   logic [NUM_REGS-1:0]                             clr_vec;
   logic                                            issue_hs;
   logic                                            dispatch_hs;
   logic                                            ops_done;
   logic                                            waw_stall;

   assign issue_ready_o = !rst_i && ((state_q == IDLE) || ((state_q == HOLD) && op_ready_i));
   assign issue_hs      = issue_valid_i && issue_ready_o;
   assign dispatch_hs   = (state_q == HOLD) && op_ready_i;
   assign raddr_o       = (state_q == WAIT_OPS) ? rs_q : '0;

   // Forwarded writeback beats the regfile; the later loop iteration (higher
   // write port) overrides earlier matches.
   always_comb begin
      avail  = '0;
      op_val = '0;
      for (int k = 0; k < NR_READ_PORTS; k++) begin
         if (ZERO_REG_ZERO && (rs_q[k] == '0)) begin
            avail[k] = 1'b1;
         end else begin
            for (int j = 0; j < NR_WRITE_PORTS; j++) begin
               if (wb_we_i[j] && (wb_addr_i[j] == rs_q[k])) begin
                  avail[k]  = 1'b1;
                  op_val[k] = wb_data_i[j];
               end
            end
            if (!avail[k] && !busy[rs_q[k]]) begin
               avail[k]  = 1'b1;
               op_val[k] = rdata_i[k];
            end
         end
      end
   end

   always_comb begin
      clr_vec = '0;
      set_vec = '0;
      for (int j = 0; j < NR_WRITE_PORTS; j++) begin
         if (wb_we_i[j]) clr_vec[wb_addr_i[j]] = 1'b1;
      end
      if (dispatch_hs && rd_we_q && (rd_q != '0)) set_vec[rd_q] = 1'b1;
   end

   assign ops_done  = &(captured_q | avail);
   assign waw_stall = rd_we_q && (rd_q != '0) && busy[rd_q] && !clr_vec[rd_q];

   ariane_scoreboard_bits #(
      .ZERO_REG_ZERO(ZERO_REG_ZERO)
   ) i_scoreboard (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .set_i (set_vec),
      .clr_i (clr_vec),
      .busy_o(busy)
   );

   // A new issue can arrive from IDLE or alongside a dispatch from HOLD, so
   // the latch of the next instruction overrides the per-state transition.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         rs_q       <= '0;
         rd_q       <= '0;
         rd_we_q    <= 1'b0;
         captured_q <= '0;
         op_data_q  <= '0;
      end else begin
         case (state_q)
            WAIT_OPS: begin
               for (int k = 0; k < NR_READ_PORTS; k++) begin
                  if (!captured_q[k] && avail[k]) begin
                     captured_q[k] <= 1'b1;
                     op_data_q[k]  <= op_val[k];
                  end
               end
               if (ops_done && !waw_stall) state_q <= HOLD;
            end
            HOLD: begin
               if (op_ready_i) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
         if (issue_hs) begin
            rs_q       <= issue_rs_i;
            rd_q       <= issue_rd_i;
            rd_we_q    <= issue_rd_we_i;
            captured_q <= '0;
            state_q    <= WAIT_OPS;
         end
      end
   end

   assign op_valid_o = (state_q == HOLD);
   assign op_data_o  = op_data_q;
   assign op_rd_o    = rd_q;
   assign op_rd_we_o = rd_we_q;

endmodule

// File: tb/tb_ariane_operand_fetch.sv
// Directed bench for the operand fetch stage with a small regfile model
// whose x0 deliberately reads back all ones.
module tb_ariane_operand_fetch;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              issue_valid_i;
   logic              issue_ready_o;
   logic [1:0][4:0]   issue_rs_i;
   logic [4:0]        issue_rd_i;
   logic              issue_rd_we_i;
   logic [1:0][4:0]   raddr_o;
   logic [1:0][31:0]  rdata_i;
   logic [1:0]        wb_we_i;
   logic [1:0][4:0]   wb_addr_i;
   logic [1:0][31:0]  wb_data_i;
   logic              op_valid_o;
   logic              op_ready_i;
   logic [1:0][31:0]  op_data_o;
   logic [4:0]        op_rd_o;
   logic              op_rd_we_o;

   logic [31:0]       regs [32];
   int                check_count = 0;
   int                fail_count  = 0;

   always #5 clk_i = ~clk_i;

   ariane_operand_fetch dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .issue_valid_i(issue_valid_i),
      .issue_ready_o(issue_ready_o),
      .issue_rs_i   (issue_rs_i),
      .issue_rd_i   (issue_rd_i),
      .issue_rd_we_i(issue_rd_we_i),
      .raddr_o      (raddr_o),
      .rdata_i      (rdata_i),
      .wb_we_i      (wb_we_i),
      .wb_addr_i    (wb_addr_i),
      .wb_data_i    (wb_data_i),
      .op_valid_o   (op_valid_o),
      .op_ready_i   (op_ready_i),
      .op_data_o    (op_data_o),
      .op_rd_o      (op_rd_o),
      .op_rd_we_o   (op_rd_we_o)
   );

   // Regfile model: xN resets to N*0x11, x0 returns all ones and ignores writes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) regs[i] <= i * 32'h11;
         regs[0] <= 32'hFFFF_FFFF;
      end else begin
         for (int j = 0; j < 2; j++) begin
            if (wb_we_i[j] && (wb_addr_i[j] != 5'd0)) regs[wb_addr_i[j]] <= wb_data_i[j];
         end
      end
   end

   always_comb begin
      rdata_i[0] = regs[raddr_o[0]];
      rdata_i[1] = regs[raddr_o[1]];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic applyStimulus(input logic [4:0] rs0, input logic [4:0] rs1,
                                input logic [4:0] rd, input logic rd_we);
      issue_valid_i = 1'b1;
      issue_rs_i[0] = rs0;
      issue_rs_i[1] = rs1;
      issue_rd_i    = rd;
      issue_rd_we_i = rd_we;
      tick();
      issue_valid_i = 1'b0;
   endtask

   task automatic setWb(input int port, input logic we, input logic [4:0] addr, input logic [31:0] data);
      wb_we_i[port]   = we;
      wb_addr_i[port] = addr;
      wb_data_i[port] = data;
   endtask

   task automatic dispatch();
      op_ready_i = 1'b1;
      tick();
      op_ready_i = 1'b0;
   endtask

   initial begin
      rst_i         = 1'b1;
      issue_valid_i = 1'b0;
      issue_rs_i    = '0;
      issue_rd_i    = '0;
      issue_rd_we_i = 1'b0;
      wb_we_i       = '0;
      wb_addr_i     = '0;
      wb_data_i     = '0;
      op_ready_i    = 1'b0;
      tick();
      tick();
      checkOutput("rst_op_valid", {31'd0, op_valid_o}, 32'd0);
      checkOutput("rst_issue_ready", {31'd0, issue_ready_o}, 32'd0);
      checkOutput("rst_op_data0", op_data_o[0], 32'd0);
      checkOutput("rst_op_rd", {27'd0, op_rd_o}, 32'd0);
      checkOutput("rst_op_rd_we", {31'd0, op_rd_we_o}, 32'd0);
      checkOutput("rst_busy", dut.busy, 32'd0);
      rst_i = 1'b0;
      #1;
      checkOutput("idle_issue_ready", {31'd0, issue_ready_o}, 32'd1);
      checkOutput("idle_raddr0", {27'd0, raddr_o[0]}, 32'd0);

      // x0 source reads zero despite regfile returning all ones; rd=0 never busy
      applyStimulus(5'd0, 5'd1, 5'd0, 1'b1);
      checkOutput("x0_wait_valid", {31'd0, op_valid_o}, 32'd0);
      checkOutput("x0_raddr1", {27'd0, raddr_o[1]}, 32'd1);
      tick();
      checkOutput("x0_valid", {31'd0, op_valid_o}, 32'd1);
      checkOutput("x0_data0", op_data_o[0], 32'd0);
      checkOutput("x0_data1", op_data_o[1], 32'h11);
      dispatch();
      checkOutput("x0_busy", dut.busy, 32'd0);
      checkOutput("x0_idle_valid", {31'd0, op_valid_o}, 32'd0);

      // Basic fetch latency, then hold with op_ready low for three cycles
      applyStimulus(5'd1, 5'd2, 5'd3, 1'b1);
      checkOutput("basic_wait_valid", {31'd0, op_valid_o}, 32'd0);
      checkOutput("basic_raddr0", {27'd0, raddr_o[0]}, 32'd1);
      checkOutput("basic_raddr1", {27'd0, raddr_o[1]}, 32'd2);
      checkOutput("basic_wait_ready", {31'd0, issue_ready_o}, 32'd0);
      tick();
      checkOutput("basic_valid", {31'd0, op_valid_o}, 32'd1);
      checkOutput("basic_data0", op_data_o[0], 32'h11);
      checkOutput("basic_data1", op_data_o[1], 32'h22);
      checkOutput("basic_rd", {27'd0, op_rd_o}, 32'd3);
      checkOutput("basic_rd_we", {31'd0, op_rd_we_o}, 32'd1);
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput("hold_valid", {31'd0, op_valid_o}, 32'd1);
         checkOutput("hold_data0", op_data_o[0], 32'h11);
         checkOutput("hold_data1", op_data_o[1], 32'h22);
         checkOutput("hold_rd", {27'd0, op_rd_o}, 32'd3);
         checkOutput("hold_busy", dut.busy, 32'd0);
      end
      op_ready_i = 1'b1;
      #1;
      checkOutput("hold_issue_ready", {31'd0, issue_ready_o}, 32'd1);
      tick();
      op_ready_i = 1'b0;
      checkOutput("dispatch_busy", dut.busy, 32'h0000_0008);
      checkOutput("dispatch_valid", {31'd0, op_valid_o}, 32'd0);

      // Busy source stalls until forwarded writeback arrives
      applyStimulus(5'd1, 5'd1, 5'd5, 1'b1);
      tick();
      dispatch();
      checkOutput("rd5_busy", dut.busy, 32'h0000_0028);
      applyStimulus(5'd5, 5'd1, 5'd6, 1'b1);
      checkOutput("stall_valid0", {31'd0, op_valid_o}, 32'd0);
      tick();
      checkOutput("stall_valid1", {31'd0, op_valid_o}, 32'd0);
      tick();
      checkOutput("stall_valid2", {31'd0, op_valid_o}, 32'd0);
      setWb(0, 1'b1, 5'd5, 32'h0000_DEAD);
      tick();
      setWb(0, 1'b0, 5'd0, 32'd0);
      checkOutput("fwd_valid", {31'd0, op_valid_o}, 32'd1);
      checkOutput("fwd_data0", op_data_o[0], 32'h0000_DEAD);
      checkOutput("fwd_data1", op_data_o[1], 32'h11);
      checkOutput("fwd_busy", dut.busy, 32'h0000_0008);
      dispatch();
      checkOutput("rd6_busy", dut.busy, 32'h0000_0048);

      // Two write ports hitting the same pending source: port 1 wins
      applyStimulus(5'd2, 5'd2, 5'd7, 1'b1);
      tick();
      dispatch();
      checkOutput("rd7_busy", dut.busy, 32'h0000_00C8);
      applyStimulus(5'd7, 5'd2, 5'd0, 1'b1);
      tick();
      checkOutput("dual_stall", {31'd0, op_valid_o}, 32'd0);
      setWb(0, 1'b1, 5'd7, 32'h0000_000A);
      setWb(1, 1'b1, 5'd7, 32'h0000_000B);
      tick();
      setWb(0, 1'b0, 5'd0, 32'd0);
      setWb(1, 1'b0, 5'd0, 32'd0);
      checkOutput("dual_valid", {31'd0, op_valid_o}, 32'd1);
      checkOutput("dual_data0", op_data_o[0], 32'h0000_000B);
      checkOutput("dual_data1", op_data_o[1], 32'h22);
      checkOutput("dual_busy", dut.busy, 32'h0000_0048);
      dispatch();
      checkOutput("rd0_dispatch_busy", dut.busy, 32'h0000_0048);

      // WAW stall on busy rd, released by a same-cycle writeback of rd
      applyStimulus(5'd1, 5'd2, 5'd3, 1'b1);
      checkOutput("waw_wait0", {31'd0, op_valid_o}, 32'd0);
      tick();
      checkOutput("waw_wait1", {31'd0, op_valid_o}, 32'd0);
      setWb(0, 1'b1, 5'd3, 32'h33);
      tick();
      setWb(0, 1'b0, 5'd0, 32'd0);
      checkOutput("waw_release", {31'd0, op_valid_o}, 32'd1);
      checkOutput("waw_busy", dut.busy, 32'h0000_0040);

      // Back-to-back dispatch+issue while a writeback clears rd: set wins
      op_ready_i    = 1'b1;
      issue_valid_i = 1'b1;
      issue_rs_i[0] = 5'd3;
      issue_rs_i[1] = 5'd3;
      issue_rd_i    = 5'd0;
      issue_rd_we_i = 1'b0;
      setWb(0, 1'b1, 5'd3, 32'h44);
      tick();
      op_ready_i    = 1'b0;
      issue_valid_i = 1'b0;
      setWb(0, 1'b0, 5'd0, 32'd0);
      checkOutput("b2b_valid", {31'd0, op_valid_o}, 32'd0);
      checkOutput("b2b_raddr0", {27'd0, raddr_o[0]}, 32'd3);
      checkOutput("setwins_busy", dut.busy, 32'h0000_0048);
      tick();
      checkOutput("b2b_stall", {31'd0, op_valid_o}, 32'd0);
      setWb(0, 1'b1, 5'd3, 32'h55);
      tick();
      setWb(0, 1'b0, 5'd0, 32'd0);
      checkOutput("b2b_fwd_valid", {31'd0, op_valid_o}, 32'd1);
      checkOutput("b2b_data0", op_data_o[0], 32'h55);
      checkOutput("b2b_data1", op_data_o[1], 32'h55);
      checkOutput("b2b_rd_we", {31'd0, op_rd_we_o}, 32'd0);
      dispatch();
      checkOutput("b2b_busy", dut.busy, 32'h0000_0040);

      // Reset while waiting on a busy source discards the instruction
      applyStimulus(5'd6, 5'd6, 5'd1, 1'b1);
      tick();
      checkOutput("midrst_wait", {31'd0, op_valid_o}, 32'd0);
      rst_i = 1'b1;
      tick();
      checkOutput("midrst_valid", {31'd0, op_valid_o}, 32'd0);
      checkOutput("midrst_busy", dut.busy, 32'd0);
      checkOutput("midrst_issue_ready", {31'd0, issue_ready_o}, 32'd0);
      checkOutput("midrst_data0", op_data_o[0], 32'd0);
      checkOutput("midrst_raddr0", {27'd0, raddr_o[0]}, 32'd0);
      rst_i = 1'b0;
      #1;
      checkOutput("midrst_idle_ready", {31'd0, issue_ready_o}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

endmodule
